// File: rtl/sample_demultiplexer.sv
// ---------------------------------------------------------------------------
// sample_demultiplexer
//
// Reassembles a stream of bytes into 48-bit samples, least-significant byte
// first, and hands each completed sample to a consumer with a rdy/ack
// handshake. While a finished sample waits for the consumer, the byte input
// is back-pressured (data_ack low), so no byte is ever dropped.
//
// Optional feature (macro DEMUX_TIMEOUT_EN): when a partial sample sits idle
// for TIMEOUT_CYCLES cycles it is discarded, collection restarts at byte 0
// and resync pulses high for one cycle. Without the macro, partial samples
// wait indefinitely and resync is tied low.
//
// Ports
//   clk          in   1   single clock for all logic
//   reset        in   1   asynchronous, active-high reset
//   data_rdy     in   1   upstream byte available
//   data         in   8   byte value, valid with data_rdy
//   data_ack     out  1   byte accepted this cycle (high while collecting)
//   sample_rdy   out  1   reassembled sample valid
//   sample       out  48  reassembled sample
//   sample_ack   in   1   consumer takes the sample this cycle
//   sample_count out  16  samples delivered since reset, wraps
//   resync       out  1   one-cycle pulse when a partial sample is discarded
//
// State  | meaning
// COLLECT| accepting bytes, idx_q selects the sample byte to write (0..5)
// HOLD   | complete sample presented, waiting for sample_ack
// ---------------------------------------------------------------------------
module sample_demultiplexer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_rdy,
    input  logic [7:0]  data,
    output logic        data_ack,
    output logic        sample_rdy,
    output logic [47:0] sample,
    input  logic        sample_ack,
    output logic [15:0] sample_count,
    output logic        resync
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  cur_idx;
    logic [47:0] sample_q, sample_d;
    logic [15:0] count_q, count_d;
    logic        xfer;
    logic        restart;

    // data_ack depends on state only, so upstream may wait on it freely.
    assign data_ack     = (state_q == COLLECT);
    assign xfer         = data_ack & data_rdy;
    assign sample_rdy   = (state_q == HOLD);
    assign sample       = sample_q;
    assign sample_count = count_q;

`ifdef DEMUX_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              resync_q;

    // The idle count only runs while a sample is partially assembled.
    assign restart = (state_q == COLLECT) && (idx_q != 3'd0) &&
                     (idle_q == IDLE_W'(TIMEOUT_CYCLES));

    always_comb begin
        idle_d = '0;
        if ((state_q == COLLECT) && (idx_q != 3'd0) && !xfer && !restart) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q   <= '0;
            resync_q <= 1'b0;
        end else begin
            idle_q   <= idle_d;
            resync_q <= restart;
        end
    end

    assign resync = resync_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign restart = 1'b0;
    assign resync  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        count_d  = count_q;
        cur_idx  = idx_q;

        case (state_q)
            COLLECT: begin
                // A byte arriving on the timeout cycle starts a fresh sample.
                cur_idx = restart ? 3'd0 : idx_q;
                idx_d   = cur_idx;
                if (xfer) begin
                    case (cur_idx)
                        3'd0:    sample_d[7:0]   = data;
                        3'd1:    sample_d[15:8]  = data;
                        3'd2:    sample_d[23:16] = data;
                        3'd3:    sample_d[31:24] = data;
                        3'd4:    sample_d[39:32] = data;
                        3'd5:    sample_d[47:40] = data;
                        default: ;
                    endcase
                    if (cur_idx == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = HOLD;
                    end else begin
                        idx_d = cur_idx + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (sample_ack) begin
                    state_d = COLLECT;
                    idx_d   = 3'd0;
                    count_d = count_q + 16'd1;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= COLLECT;
            idx_q    <= 3'd0;
            sample_q <= 48'd0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/sample_demultiplexer.md
SAMPLE_DEMULTIPLEXER -- requirements
Module: sample_demultiplexer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, idle cycles before a partial sample is discarded (used only with DEMUX_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_rdy  input  1  byte available from upstream byte source.
REQ-005 SHALL have port data  input  8  byte value; valid when data_rdy high.
REQ-006 SHALL have port data_ack  output  1  byte accepted this cycle.
REQ-007 SHALL have port sample_rdy  output  1  reassembled 48-bit sample valid.
REQ-008 SHALL have port sample  output  48  reassembled sample.
REQ-009 SHALL have port sample_ack  input  1  consumer takes sample this cycle.
REQ-010 SHALL have port sample_count  output  16  samples delivered since reset, wraps.
REQ-011 SHALL have port resync  output  1  one-cycle pulse when a partial sample is discarded.

Function
REQ-012 SHALL transfer a byte only on a clk edge where data_rdy and data_ack are both high.
REQ-013 SHALL assemble bytes least-significant first: byte 0 -> sample[7:0], byte 5 -> sample[47:40].
REQ-014 SHALL implement states COLLECT (byte index 0..5) and HOLD.
REQ-015 SHALL drive data_ack = 1 in COLLECT, 0 in HOLD (combinational from state only, never from data_rdy).
REQ-016 SHALL, on transfer of byte index 5, enter HOLD with sample_rdy high on the next cycle (latency one cycle after last byte).
REQ-017 SHALL keep sample stable and sample_rdy high in HOLD until sample_ack is sampled high.
REQ-018 SHALL, on sample_ack in HOLD, return to COLLECT at index 0, deassert sample_rdy next cycle, increment sample_count by 1.
REQ-019 SHALL ignore sample_ack outside HOLD.
REQ-020 SHALL wrap sample_count from 16'hFFFF to 0 with no flag.
REQ-021 SHALL leave unwritten sample bytes holding their previous value during COLLECT; sample is only meaningful while sample_rdy high.
REQ-022 SHALL increment byte index modulo 6; index never takes values 6 or 7.

Reset
REQ-023 SHALL, on reset assertion (any time, including mid-sample or in HOLD), immediately force: state COLLECT, index 0, sample_rdy 0, sample 0, sample_count 0, resync 0, idle counter 0.
REQ-024 SHALL drive data_ack = 1 one cycle after reset deassertion at the latest and accept no byte while reset is high.

Configuration
REQ-025 SHALL compile a resync timeout under macro DEMUX_TIMEOUT_EN.
REQ-026 With DEMUX_TIMEOUT_EN: idle counter counts cycles in COLLECT with index != 0 and no transfer; cleared on any transfer or at index 0.
REQ-027 With DEMUX_TIMEOUT_EN: when idle counter reaches TIMEOUT_CYCLES, index SHALL return to 0 and resync SHALL pulse high one cycle; a byte transferring that same cycle SHALL be taken as byte 0 of a new sample.
REQ-028 Without DEMUX_TIMEOUT_EN: no idle counter, partial samples wait indefinitely, resync tied to 0.

Verification
REQ-029 Bytes EF ED BE AD DE FE, data_rdy continuous -> sample_rdy high one cycle after 6th transfer, sample = 48'hFEDEADBEEDEF, sample_count = 1 after ack.
REQ-030 Hold sample_ack low 20 cycles with data_rdy high -> data_ack low throughout, sample unchanged, no bytes lost; ack -> next 6 bytes form next sample.
REQ-031 Assert reset after 3 bytes -> outputs at reset values; following 6 bytes 01..06 -> sample = 48'h060504030201.
REQ-032 Deliver 65536 samples -> sample_count returns to 0, sample_rdy behaviour unchanged.
REQ-033 DEMUX_TIMEOUT_EN, TIMEOUT_CYCLES=255: 2 bytes then 255 idle cycles -> resync pulses once, next 6 bytes 11..16 give 48'h161514131211.
REQ-034 Without DEMUX_TIMEOUT_EN: 2 bytes, 1000 idle cycles, 4 bytes -> single sample from all 6 bytes, resync never high.
